// File: rtl/frame_buf_pkg.sv
// Shared types, reset indices and the buffer-index to base-address helper
// for the triple-buffer frame store controller.
package frame_buf_pkg;

  typedef logic [1:0] buf_idx_t;

  localparam buf_idx_t WR_RST  = 2'd0;
  localparam buf_idx_t RDY_RST = 2'd1;
  localparam buf_idx_t RD_RST  = 2'd2;

  localparam int ADDR_DW = 21;
  typedef logic [ADDR_DW-1:0] addr_t;

  // Index 3 never occurs in a valid permutation; it falls back to buffer 0.
  function automatic addr_t idx_to_base(input buf_idx_t idx, input addr_t b0,
                                        input addr_t b1, input addr_t b2);
    addr_t base;
    case (idx)
      2'd0:    base = b0;
      2'd1:    base = b1;
      2'd2:    base = b2;
      default: base = b0;
    endcase
    return base;
  endfunction

endpackage

// File: rtl/frame_buf_ctrl_pulse_rise_det.sv
// pulse_rise_det: one-register rising-edge detector; a level held high
// yields a single-cycle edge.
module pulse_rise_det (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_sig,
  output logic o_rise
);

  logic sig_q;

  // One-cycle history of the strobe.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sig_q <= 1'b0;
    end else begin
      sig_q <= i_sig;
    end
  end

  assign o_rise = i_sig & ~sig_q;

endmodule

// File: rtl/frame_buf_ctrl.sv
// frame_buf_ctrl: triple-buffer manager (write / ready / read indices) for the
// SDRAM frame store. Optional drop counter enabled by FRAME_DROP_CNT_EN.
module frame_buf_ctrl
  import frame_buf_pkg::*;
#(
  parameter int                      SDRAM_ADDRS_DW    = 21,
  parameter logic [SDRAM_ADDRS_DW-1:0] BUF0_BASE       = 21'h000000,
  parameter logic [SDRAM_ADDRS_DW-1:0] BUF1_BASE       = 21'h010000,
  parameter logic [SDRAM_ADDRS_DW-1:0] BUF2_BASE       = 21'h020000,
  parameter int                      IMAGE_WIDE_LENGTH = 256,
  parameter int                      IMAGE_HIGH_LENGTH = 192
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_wr_frame_start,
  input  logic                      i_wr_frame_done,
  input  logic                      i_rd_frame_start,
  output logic                      o_wr_start,
  output logic [SDRAM_ADDRS_DW-1:0] o_wr_addrs,
  output logic                      o_rd_start,
  output logic [SDRAM_ADDRS_DW-1:0] o_rd_addrs,
  output logic [1:0]                o_mem_cnt,
  output logic                      o_frame_avail,
  output logic [31:0]               o_data_length,
  output logic [15:0]               o_drop_cnt
);

  logic wr_start_e_s;
  logic wr_done_e_s;
  logic rd_start_e_s;

  buf_idx_t wr_idx_q, wr_idx_d;
  buf_idx_t rdy_idx_q, rdy_idx_d;
  buf_idx_t rd_idx_q, rd_idx_d;
  logic     fresh_q, fresh_d;
  logic     has_frame_q, has_frame_d;
  logic     wr_busy_q, wr_busy_d;
  logic     wr_start_q, wr_start_d;
  logic     rd_start_q, rd_start_d;
  logic     drop_evt_s;
  logic [SDRAM_ADDRS_DW-1:0] wr_addrs_q, wr_addrs_d;
  logic [SDRAM_ADDRS_DW-1:0] rd_addrs_q, rd_addrs_d;

  pulse_rise_det u_wr_start_det (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_sig   (i_wr_frame_start),
    .o_rise  (wr_start_e_s)
  );

  pulse_rise_det u_wr_done_det (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_sig   (i_wr_frame_done),
    .o_rise  (wr_done_e_s)
  );

  pulse_rise_det u_rd_start_det (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_sig   (i_rd_frame_start),
    .o_rise  (rd_start_e_s)
  );

  // Index permutation update: write-done swap first, then write start, then read swap.
  always_comb begin
    wr_idx_d    = wr_idx_q;
    rdy_idx_d   = rdy_idx_q;
    rd_idx_d    = rd_idx_q;
    fresh_d     = fresh_q;
    has_frame_d = has_frame_q;
    wr_busy_d   = wr_busy_q;
    wr_start_d  = 1'b0;
    rd_start_d  = 1'b0;
    drop_evt_s  = 1'b0;

    if (wr_done_e_s && wr_busy_q) begin
      wr_idx_d    = rdy_idx_q;
      rdy_idx_d   = wr_idx_q;
      drop_evt_s  = fresh_q;
      fresh_d     = 1'b1;
      has_frame_d = 1'b1;
      wr_busy_d   = 1'b0;
    end else begin
      drop_evt_s  = 1'b0;
    end

    // A start while busy aborts the frame and simply reissues on the same buffer.
    if (wr_start_e_s) begin
      wr_busy_d  = 1'b1;
      wr_start_d = 1'b1;
    end else begin
      wr_start_d = 1'b0;
    end

    if (rd_start_e_s && has_frame_d) begin
      rd_start_d = 1'b1;
      if (fresh_d) begin
        rd_idx_d  = rdy_idx_d;
        rdy_idx_d = rd_idx_q;
        fresh_d   = 1'b0;
      end else begin
        rd_idx_d  = rd_idx_q;
      end
    end else begin
      rd_start_d = 1'b0;
    end

    wr_addrs_d = SDRAM_ADDRS_DW'(idx_to_base(wr_idx_d, addr_t'(BUF0_BASE),
                                             addr_t'(BUF1_BASE), addr_t'(BUF2_BASE)));
    rd_addrs_d = SDRAM_ADDRS_DW'(idx_to_base(rd_idx_d, addr_t'(BUF0_BASE),
                                             addr_t'(BUF1_BASE), addr_t'(BUF2_BASE)));
  end

  // State and registered outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_idx_q    <= WR_RST;
      rdy_idx_q   <= RDY_RST;
      rd_idx_q    <= RD_RST;
      fresh_q     <= 1'b0;
      has_frame_q <= 1'b0;
      wr_busy_q   <= 1'b0;
      wr_start_q  <= 1'b0;
      rd_start_q  <= 1'b0;
      wr_addrs_q  <= BUF0_BASE;
      rd_addrs_q  <= BUF2_BASE;
    end else begin
      wr_idx_q    <= wr_idx_d;
      rdy_idx_q   <= rdy_idx_d;
      rd_idx_q    <= rd_idx_d;
      fresh_q     <= fresh_d;
      has_frame_q <= has_frame_d;
      wr_busy_q   <= wr_busy_d;
      wr_start_q  <= wr_start_d;
      rd_start_q  <= rd_start_d;
      wr_addrs_q  <= wr_addrs_d;
      rd_addrs_q  <= rd_addrs_d;
    end
  end

`ifdef FRAME_DROP_CNT_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;

  // Saturating count of completed frames overwritten before any read took them.
  always_comb begin
    if (drop_evt_s && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end else begin
      drop_cnt_d = drop_cnt_q;
    end
  end

  // Drop counter register, cleared only by reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      drop_cnt_q <= 16'd0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign o_drop_cnt = drop_cnt_q;
`else
  logic unused_drop_s;
  assign unused_drop_s = drop_evt_s;
  assign o_drop_cnt    = 16'd0;
`endif

  assign o_wr_start    = wr_start_q;
  assign o_wr_addrs    = wr_addrs_q;
  assign o_rd_start    = rd_start_q;
  assign o_rd_addrs    = rd_addrs_q;
  assign o_mem_cnt     = rd_idx_q;
  assign o_frame_avail = has_frame_q;
  assign o_data_length = 32'(IMAGE_WIDE_LENGTH * IMAGE_HIGH_LENGTH);

endmodule

// File: tb/tb_frame_buf_ctrl.sv
// Self-checking bench for frame_buf_ctrl: directed literal checks plus random
// strobes compared every cycle against a role-array model.
module tb_frame_buf_ctrl;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        ws    = 1'b0;
  logic        wd    = 1'b0;
  logic        rs    = 1'b0;
  logic        o_wr_start, o_rd_start, o_frame_avail;
  logic [20:0] o_wr_addrs, o_rd_addrs;
  logic [1:0]  o_mem_cnt;
  logic [31:0] o_data_length;
  logic [15:0] o_drop_cnt;

  frame_buf_ctrl dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_wr_frame_start (ws),
    .i_wr_frame_done  (wd),
    .i_rd_frame_start (rs),
    .o_wr_start       (o_wr_start),
    .o_wr_addrs       (o_wr_addrs),
    .o_rd_start       (o_rd_start),
    .o_rd_addrs       (o_rd_addrs),
    .o_mem_cnt        (o_mem_cnt),
    .o_frame_avail    (o_frame_avail),
    .o_data_length    (o_data_length),
    .o_drop_cnt       (o_drop_cnt)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [20:0] base [3] = '{21'h000000, 21'h010000, 21'h020000};
  int m_wr, m_rdy, m_rd, m_drop;
  bit m_fresh, m_has, m_busy;
  bit ws_p, wd_p, rs_p;
  bit e_wr_start, e_rd_start;

`ifdef FRAME_DROP_CNT_EN
  localparam bit DROP_EN = 1'b1;
`else
  localparam bit DROP_EN = 1'b0;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_wr = 0; m_rdy = 1; m_rd = 2; m_drop = 0;
    m_fresh = 0; m_has = 0; m_busy = 0;
    ws_p = 0; wd_p = 0; rs_p = 0;
    e_wr_start = 0; e_rd_start = 0;
  endtask

  task automatic model_step();
    bit wse, wde, rse;
    int t;
    wse = ws && !ws_p;
    wde = wd && !wd_p;
    rse = rs && !rs_p;
    if (wde && m_busy) begin
      t = m_wr; m_wr = m_rdy; m_rdy = t;
      if (m_fresh && m_drop < 65535) m_drop++;
      m_fresh = 1; m_has = 1; m_busy = 0;
    end
    if (wse) m_busy = 1;
    e_wr_start = wse;
    e_rd_start = 0;
    if (rse && m_has) begin
      if (m_fresh) begin
        t = m_rd; m_rd = m_rdy; m_rdy = t;
        m_fresh = 0;
      end
      e_rd_start = 1;
    end
    ws_p = ws; wd_p = wd; rs_p = rs;
  endtask

  task automatic compare_all();
    check("m_wr_start", 32'(o_wr_start), 32'(e_wr_start));
    check("m_rd_start", 32'(o_rd_start), 32'(e_rd_start));
    check("m_wr_addrs", 32'(o_wr_addrs), 32'(base[m_wr]));
    check("m_rd_addrs", 32'(o_rd_addrs), 32'(base[m_rd]));
    check("m_mem_cnt", 32'(o_mem_cnt), 32'(m_rd));
    check("m_avail", 32'(o_frame_avail), 32'(m_has));
    check("m_drop", 32'(o_drop_cnt), DROP_EN ? 32'(m_drop) : 32'd0);
    check("m_len", o_data_length, 32'd49152);
  endtask

  // Reference model advanced on every rising edge, compared just after.
  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      if (!rst_n) model_reset();
      else model_step();
      #1;
      compare_all();
    end
  end

  task automatic cyc(input bit a, input bit b, input bit c);
    @(negedge clk);
    ws = a; wd = b; rs = c;
    @(posedge clk);
    #2;
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_wr_start"}, 32'(o_wr_start), 32'd0);
    check({tag, "_rd_start"}, 32'(o_rd_start), 32'd0);
    check({tag, "_wr_addrs"}, 32'(o_wr_addrs), 32'h000000);
    check({tag, "_rd_addrs"}, 32'(o_rd_addrs), 32'h020000);
    check({tag, "_mem_cnt"}, 32'(o_mem_cnt), 32'd2);
    check({tag, "_avail"}, 32'(o_frame_avail), 32'd0);
    check({tag, "_drop"}, 32'(o_drop_cnt), 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset_checks("rst");
    rst_n = 1'b1;

    // Read before any frame: ignored.
    cyc(0, 0, 1);
    check("rd_noframe", 32'(o_rd_start), 32'd0);
    check("rd_noframe_cnt", 32'(o_mem_cnt), 32'd2);
    check("rd_noframe_avail", 32'(o_frame_avail), 32'd0);
    cyc(0, 0, 0);

    // First frame into buffer 0, then read it twice.
    cyc(1, 0, 0);
    check("wr1_start", 32'(o_wr_start), 32'd1);
    check("wr1_addr", 32'(o_wr_addrs), 32'h000000);
    cyc(0, 1, 0);
    check("wr1_nostart", 32'(o_wr_start), 32'd0);
    check("wr1_done_addr", 32'(o_wr_addrs), 32'h010000);
    check("wr1_avail", 32'(o_frame_avail), 32'd1);
    cyc(0, 0, 1);
    check("rd1_start", 32'(o_rd_start), 32'd1);
    check("rd1_addr", 32'(o_rd_addrs), 32'h000000);
    check("rd1_cnt", 32'(o_mem_cnt), 32'd0);
    cyc(0, 0, 0);
    cyc(0, 0, 1);
    check("rd_rep_start", 32'(o_rd_start), 32'd1);
    check("rd_rep_addr", 32'(o_rd_addrs), 32'h000000);

    // Abort: two starts then one done give a single swap; a stray done is ignored.
    cyc(1, 0, 0);
    check("ab_start1", 32'(o_wr_addrs), 32'h010000);
    cyc(0, 0, 0);
    cyc(1, 0, 0);
    check("ab_start2", 32'(o_wr_start), 32'd1);
    check("ab_start2_addr", 32'(o_wr_addrs), 32'h010000);
    cyc(0, 1, 0);
    check("ab_done_addr", 32'(o_wr_addrs), 32'h020000);
    cyc(0, 0, 0);
    cyc(0, 1, 0);
    check("idle_done_addr", 32'(o_wr_addrs), 32'h020000);
    check("idle_done_cnt", 32'(o_mem_cnt), 32'd0);

    // Write-done and read-start together: write swap then read swap.
    cyc(1, 0, 0);
    check("sim_start_addr", 32'(o_wr_addrs), 32'h020000);
    cyc(0, 0, 0);
    cyc(0, 1, 1);
    check("sim_rd_start", 32'(o_rd_start), 32'd1);
    check("sim_rd_addr", 32'(o_rd_addrs), 32'h020000);
    check("sim_cnt", 32'(o_mem_cnt), 32'd2);
    check("sim_wr_addr", 32'(o_wr_addrs), 32'h010000);
    check("sim_drop", 32'(o_drop_cnt), DROP_EN ? 32'd1 : 32'd0);

    // Write-start and write-done together: start lands on the swapped buffer.
    cyc(0, 0, 0);
    cyc(1, 0, 0);
    cyc(0, 0, 0);
    cyc(1, 1, 0);
    check("sd_start", 32'(o_wr_start), 32'd1);
    check("sd_addr", 32'(o_wr_addrs), 32'h000000);

    // Asynchronous reset mid-frame.
    @(negedge clk);
    rst_n = 1'b0; ws = 0; wd = 0; rs = 0;
    #1;
    reset_checks("midrst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Three frames with no reads, then a read picks the newest.
    for (int f = 0; f < 3; f++) begin
      cyc(1, 0, 0);
      cyc(0, 0, 0);
      cyc(0, 1, 0);
      cyc(0, 0, 0);
    end
    check("drop3", 32'(o_drop_cnt), DROP_EN ? 32'd2 : 32'd0);
    cyc(0, 0, 1);
    check("drop3_rd_addr", 32'(o_rd_addrs), 32'h000000);
    check("drop3_rd_cnt", 32'(o_mem_cnt), 32'd0);
    cyc(0, 0, 0);

    // Random strobes with occasional resets; the model process checks each cycle.
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      ws = ($urandom_range(0, 5) == 0);
      wd = ($urandom_range(0, 4) == 0);
      rs = ($urandom_range(0, 5) == 0);
      rst_n = ($urandom_range(0, 499) != 0);
    end
    @(negedge clk);
    rst_n = 1'b1; ws = 0; wd = 0; rs = 0;
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/frame_buf_ctrl.md
Name: frame_buf_ctrl

Overview:
- Triple-buffer manager for the SDRAM frame store shared by the IR video writer (sensor capture) and the display reader.
- Keeps three buffer indices as a permutation (write, ready, read), so the reader never reads the buffer being written and always gets the newest completed frame.
- Issues per-frame start pulses with the matching base address to the SDRAM write and read engines.

Parameters:
- SDRAM_ADDRS_DW, 21, SDRAM address width.
- BUF0_BASE, 21'h000000, base address of buffer 0.
- BUF1_BASE, 21'h010000, base address of buffer 1.
- BUF2_BASE, 21'h020000, base address of buffer 2.
- IMAGE_WIDE_LENGTH, 256, pixels per line.
- IMAGE_HIGH_LENGTH, 192, lines per frame.

Ports:
- i_clk  in  1  system clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_wr_frame_start  in  1  writer frame-start strobe; rising-edge detected.
- i_wr_frame_done  in  1  writer frame-complete strobe; rising-edge detected.
- i_rd_frame_start  in  1  reader frame request; rising-edge detected.
- o_wr_start  out  1  one-cycle pulse to the SDRAM write engine.
- o_wr_addrs  out  SDRAM_ADDRS_DW  base address of the current write buffer.
- o_rd_start  out  1  one-cycle pulse to the SDRAM read engine.
- o_rd_addrs  out  SDRAM_ADDRS_DW  base address of the current read buffer.
- o_mem_cnt  out  2  index of the current read buffer.
- o_frame_avail  out  1  at least one frame has completed since reset.
- o_data_length  out  32  IMAGE_WIDE_LENGTH*IMAGE_HIGH_LENGTH (constant).
- o_drop_cnt  out  16  frames overwritten without being read (see Optional Feature).

Behaviour:
- Reset (async assert, sync release): wr_idx=0, rdy_idx=1, rd_idx=2; fresh=0, has_frame=0, wr_busy=0. All pulses 0; o_wr_addrs=BUF0_BASE; o_rd_addrs=BUF2_BASE; o_mem_cnt=2; o_drop_cnt=0.
- Edge detection: each strobe has a one-register history. edge = in & ~in_d, so a level held high counts once. History registers reset to 0.
- Write-start edge:
  - Sets wr_busy=1.
  - o_wr_start pulses the next cycle (latency 1) with o_wr_addrs = base of wr_idx.
  - If wr_busy was already set, the previous frame is aborted: no swap, and the start is reissued on the same wr_idx.
- Write-done edge:
  - Ignored when wr_busy=0.
  - Otherwise swaps wr_idx and rdy_idx, then sets fresh=1, has_frame=1 and wr_busy=0.
  - o_wr_addrs updates 1 cycle later. No o_wr_start is issued; the writer must send a new start.
- Read-start edge:
  - If has_frame=0: ignored, and no o_rd_start is issued.
  - Else if fresh=1: swaps rd_idx and rdy_idx and clears fresh.
  - Else: rd_idx is unchanged, so the last frame is repeated.
  - In both non-ignored cases, o_rd_start pulses the next cycle with o_rd_addrs and o_mem_cnt already at the new rd_idx.
- Simultaneous write-done and read-start in the same cycle: the write swap is applied first, then the read swap. Result: rd ← old wr, rdy ← old rd, wr ← old rdy, fresh=0.
- Simultaneous write-start and write-done: done is processed first (swap), then start on the new wr_idx. o_wr_start carries the new address.
- Invariant: {wr_idx, rdy_idx, rd_idx} is always a permutation of {0,1,2}. Index 3 is never produced; the address mux default is BUF0_BASE.
- Reset mid-frame returns all state to the reset values. Outstanding engine activity is the engines' concern.

Optional Feature:
- Macro: FRAME_DROP_CNT_EN.
- Defined: o_drop_cnt increments when a valid write-done arrives while fresh=1. It saturates at 16'hFFFF and clears only on reset.
- Undefined: o_drop_cnt is tied to 0 and no counter logic is built.

Decomposition:
- Shared package frame_buf_pkg holds:
  - buffer index typedef (2-bit);
  - reset index constants WR_RST=0, RDY_RST=1, RD_RST=2;
  - index-to-base-address function.
- One natural sub-module: pulse_rise_det (1-bit rising-edge detector with async active-low reset), instantiated three times.

Test Plan:
- Reset then a read request → no o_rd_start; o_frame_avail=0; o_mem_cnt=2.
- wr start, wr done, rd start → o_wr_start with BUF0_BASE; afterwards wr_idx=1; o_rd_start with o_rd_addrs=BUF0_BASE and o_mem_cnt=0.
- Two consecutive rd starts with no new frame → both issue o_rd_start with the same address (repeat).
- With FRAME_DROP_CNT_EN: three complete write frames, no reads → o_drop_cnt=2; next read gets the third frame's buffer.
- Write-done and read-start in the same cycle from state wr=0, rdy=1, rd=2 with fresh=0 → rd=0, rdy=2, wr=1; o_rd_addrs=BUF0_BASE.
- wr start, wr start again (abort), wr done → a single swap; write-done with wr_busy=0 → ignored, indices unchanged; async reset asserted mid-frame → all outputs return to reset values immediately.
